// File: rtl/ysyx_22041207_rd_arbiter.sv
// rtl/ysyx_22041207_rd_arbiter.sv - two-requester read-port arbiter, MEM priority with IF starvation guard
module ysyx_22041207_rd_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch requester
    input  logic              m0_r_valid_i,
    output logic              m0_r_ready_o,
    input  logic [ADDR_W-1:0] m0_r_addr_i,
    input  logic [7:0]        m0_r_size_i,
    output logic [DATA_W-1:0] m0_data_read_o,
    output logic              m0_data_valid,
    input  logic              m0_data_ready,
    // load path requester
    input  logic              m1_r_valid_i,
    output logic              m1_r_ready_o,
    input  logic [ADDR_W-1:0] m1_r_addr_i,
    input  logic [7:0]        m1_r_size_i,
    output logic [DATA_W-1:0] m1_data_read_o,
    output logic              m1_data_valid,
    input  logic              m1_data_ready,
    // read bridge side
    output logic              rx_r_valid_i,
    input  logic              rx_r_ready_o,
    output logic [ADDR_W-1:0] rx_r_addr_i,
    output logic [7:0]        rx_r_size_i,
    input  logic [DATA_W-1:0] rx_data_read_o,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic [1:0]        grant_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              rx_valid_q, rx_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        size_q, size_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic in_idle, in_data, starved, pick_m0, pick_m1;

    // Grant decision: MEM wins unless IF has already been passed over STARVE_LIMIT times
    always_comb begin
        in_idle = (state_q == S_IDLE);
        in_data = (state_q == S_DATA);
        starved = m0_r_valid_i && (starve_q == CNT_W'(STARVE_LIMIT));
        pick_m1 = in_idle && m1_r_valid_i && !starved;
        pick_m0 = in_idle && !pick_m1 && m0_r_valid_i;
    end

    // Next-state: one transaction at a time, IDLE -> ADDR -> DATA -> IDLE
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rx_valid_d = rx_valid_q;
        addr_d     = addr_q;
        size_d     = size_q;
        starve_d   = starve_q;
        case (state_q)
            S_IDLE: begin
                if (pick_m1) begin
                    grant_d    = 2'b10;
                    addr_d     = m1_r_addr_i;
                    size_d     = m1_r_size_i;
                    rx_valid_d = 1'b1;
                    state_d    = S_ADDR;
                end else if (pick_m0) begin
                    grant_d    = 2'b01;
                    addr_d     = m0_r_addr_i;
                    size_d     = m0_r_size_i;
                    rx_valid_d = 1'b1;
                    state_d    = S_ADDR;
                end
                // IF served or not waiting: its starvation history is forgiven
                if (pick_m0 || !m0_r_valid_i) begin
                    starve_d = '0;
                end else if (pick_m1 && (starve_q < CNT_W'(STARVE_LIMIT))) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            S_ADDR: begin
                if (rx_valid_q && rx_r_ready_o) begin
                    rx_valid_d = 1'b0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_data_valid && rx_data_ready) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = 2'b00;
                rx_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            rx_valid_q <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rx_valid_q <= rx_valid_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            starve_q   <= starve_d;
        end
    end

    // Output steering: accept pulses in IDLE, data handshake passed through to the owner in DATA
    always_comb begin
        m0_r_ready_o   = pick_m0;
        m1_r_ready_o   = pick_m1;
        rx_r_valid_i   = rx_valid_q;
        rx_r_addr_i    = addr_q;
        rx_r_size_i    = size_q;
        grant_o        = grant_q;
        m0_data_read_o = rx_data_read_o;
        m1_data_read_o = rx_data_read_o;
        m0_data_valid  = in_data && grant_q[0] && rx_data_valid;
        m1_data_valid  = in_data && grant_q[1] && rx_data_valid;
        rx_data_ready  = in_data && ((grant_q[0] && m0_data_ready) || (grant_q[1] && m1_data_ready));
    end

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// tb/tb_ysyx_22041207_rd_arbiter.sv - scoreboard bench for the read-port arbiter
module tb_ysyx_22041207_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_r_valid_i = 1'b0, m1_r_valid_i = 1'b0;
    logic        m0_r_ready_o, m1_r_ready_o;
    logic [63:0] m0_r_addr_i = '0, m1_r_addr_i = '0;
    logic [7:0]  m0_r_size_i = '0, m1_r_size_i = '0;
    logic [63:0] m0_data_read_o, m1_data_read_o;
    logic        m0_data_valid, m1_data_valid;
    logic        m0_data_ready = 1'b1, m1_data_ready = 1'b1;
    logic        rx_r_valid_i;
    logic        rx_r_ready_o = 1'b0;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic [63:0] rx_data_read_o = '0;
    logic        rx_data_valid = 1'b0;
    logic        rx_data_ready;
    logic [1:0]  grant_o;

    ysyx_22041207_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_r_valid_i(m0_r_valid_i), .m0_r_ready_o(m0_r_ready_o), .m0_r_addr_i(m0_r_addr_i),
        .m0_r_size_i(m0_r_size_i), .m0_data_read_o(m0_data_read_o), .m0_data_valid(m0_data_valid),
        .m0_data_ready(m0_data_ready),
        .m1_r_valid_i(m1_r_valid_i), .m1_r_ready_o(m1_r_ready_o), .m1_r_addr_i(m1_r_addr_i),
        .m1_r_size_i(m1_r_size_i), .m1_data_read_o(m1_data_read_o), .m1_data_valid(m1_data_valid),
        .m1_data_ready(m1_data_ready),
        .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o), .rx_r_addr_i(rx_r_addr_i),
        .rx_r_size_i(rx_r_size_i), .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  g;
        logic [63:0] a;
        logic [7:0]  s;
    } grant_t;

    grant_t      exp_grant[$];
    logic [63:0] exp_d0[$];
    logic [63:0] exp_d1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          r0_pulses = 0;
    int          addr_delay = 0;
    bit          bridge_en = 1'b1;

    function automatic logic [63:0] memf(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0000_0297;
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [63:0] a, input logic [7:0] s);
        exp_grant.push_back({g, a, s});
        if (g == 2'b01) exp_d0.push_back(memf(a));
        else exp_d1.push_back(memf(a));
    endtask

    // requester: raise valid, hold until accepted, then drop it
    task automatic req(input int p, input logic [63:0] a, input logic [7:0] s);
        int n = 0;
        logic rdy;
        @(negedge clk);
        if (p == 0) begin m0_r_valid_i = 1'b1; m0_r_addr_i = a; m0_r_size_i = s; end
        else begin m1_r_valid_i = 1'b1; m1_r_addr_i = a; m1_r_size_i = s; end
        #1;
        rdy = (p == 0) ? m0_r_ready_o : m1_r_ready_o;
        while (!rdy && n < 300) begin
            @(negedge clk); #1;
            rdy = (p == 0) ? m0_r_ready_o : m1_r_ready_o;
            n++;
        end
        if (!rdy) begin
            chk("req_accept_timeout", 64'(rdy), 64'd1);
            if (p == 0) m0_r_valid_i = 1'b0; else m1_r_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (p == 0) m0_r_valid_i = 1'b0; else m1_r_valid_i = 1'b0;
        chk("accept_latency", 64'(rx_r_valid_i), 64'd1);
        chk("grant_owner", 64'(grant_o), (p == 0) ? 64'd1 : 64'd2);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_grant.size() != 0 || exp_d0.size() != 0 || exp_d1.size() != 0 || grant_o != 2'b00) && n < 500) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 64'(n), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_ready"}, 64'({m0_r_ready_o, m1_r_ready_o}), 64'd0);
        chk({tag, "_m_dvalid"}, 64'({m0_data_valid, m1_data_valid}), 64'd0);
        chk({tag, "_rx_valid"}, 64'(rx_r_valid_i), 64'd0);
        chk({tag, "_rx_addr"}, rx_r_addr_i, 64'd0);
        chk({tag, "_rx_size"}, 64'(rx_r_size_i), 64'd0);
        chk({tag, "_rx_dready"}, 64'(rx_data_ready), 64'd0);
        chk({tag, "_grant"}, 64'(grant_o), 64'd0);
    endtask

    // bridge model: optional address stall, then one data beat held until taken
    initial begin
        logic [63:0] a;
        int n;
        forever begin
            @(negedge clk); #1;
            if (bridge_en && rx_r_valid_i) begin
                repeat (addr_delay) @(negedge clk);
                rx_r_ready_o = 1'b1;
                a = rx_r_addr_i;
                @(posedge clk); #1;
                rx_r_ready_o = 1'b0;
                @(negedge clk);
                rx_data_read_o = memf(a);
                rx_data_valid = 1'b1;
                #1;
                n = 0;
                while (!rx_data_ready && n < 100) begin @(negedge clk); #1; n++; end
                if (n >= 100) chk("bridge_data_timeout", 64'(n), 64'd0);
                @(posedge clk); #1;
                rx_data_valid = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a handshake
    initial begin
        grant_t e;
        logic [63:0] d;
        forever begin
            @(negedge clk); #4;
            if (m0_r_ready_o) r0_pulses++;
            if (m0_r_ready_o && m1_r_ready_o) chk("both_ready", 64'd1, 64'd0);
            if (grant_o != 2'b00)
                chk("dvalid_owner_only", 64'({m0_data_valid && grant_o != 2'b01, m1_data_valid && grant_o != 2'b10}), 64'd0);
            if (rx_r_valid_i && rx_r_ready_o) begin
                if (exp_grant.size() == 0) chk("unexpected_addr", rx_r_addr_i, 64'd0);
                else begin
                    e = exp_grant.pop_front();
                    chk("addr_grant", 64'(grant_o), 64'(e.g));
                    chk("addr_value", rx_r_addr_i, e.a);
                    chk("addr_size", 64'(rx_r_size_i), 64'(e.s));
                end
            end
            if (m0_data_valid && m0_data_ready) begin
                if (exp_d0.size() == 0) chk("unexpected_m0_data", m0_data_read_o, 64'd0);
                else begin d = exp_d0.pop_front(); chk("m0_data", m0_data_read_o, d); end
            end
            if (m1_data_valid && m1_data_ready) begin
                if (exp_d1.size() == 0) chk("unexpected_m1_data", m1_data_read_o, 64'd0);
                else begin d = exp_d1.pop_front(); chk("m1_data", m1_data_read_o, d); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("release");

        // single IF read
        r0_pulses = 0;
        push(2'b01, 64'h8000_0000, 8'h0f);
        req(0, 64'h8000_0000, 8'h0f);
        wait_done();
        chk("t1_ready_pulses", 64'(r0_pulses), 64'd1);
        chk("t1_grant_idle", 64'(grant_o), 64'd0);

        // simultaneous requests: MEM first, IF after the bubble
        push(2'b10, 64'h8000_1000, 8'h0f);
        push(2'b01, 64'h8000_0000, 8'h0f);
        fork
            req(0, 64'h8000_0000, 8'h0f);
            req(1, 64'h8000_1000, 8'h0f);
        join
        wait_done();

        // MEM streams while IF waits: m1 x4, m0, m1
        for (int i = 0; i < 4; i++) push(2'b10, 64'h9000_0000 + 64'(i * 8), 8'h03);
        push(2'b01, 64'h8000_0040, 8'h0f);
        push(2'b10, 64'h9000_0020, 8'h03);
        fork
            begin
                req(0, 64'h8000_0040, 8'h0f);
                chk("t3_starve_cleared", 64'(dut.starve_q), 64'd0);
            end
            begin
                for (int i = 0; i < 5; i++) req(1, 64'h9000_0000 + 64'(i * 8), 8'h03);
            end
        join
        wait_done();

        // address stall then data back-pressure
        addr_delay = 5;
        m0_data_ready = 1'b0;
        push(2'b01, 64'h8000_0100, 8'h07);
        fork
            req(0, 64'h8000_0100, 8'h07);
            begin
                int n = 0;
                @(negedge clk); #2;
                while (!m0_data_valid && n < 100) begin @(negedge clk); #2; n++; end
                if (n >= 100) chk("t4_dvalid_timeout", 64'(n), 64'd0);
                repeat (3) @(negedge clk);
                m0_data_ready = 1'b1;
            end
            begin
                int n = 0;
                int busy = 0;
                @(negedge clk); #3;
                while (grant_o == 2'b00 && n < 100) begin @(negedge clk); #3; n++; end
                while (grant_o != 2'b00 && busy < 60) begin
                    chk("t4_addr_stable", rx_r_addr_i, 64'h8000_0100);
                    chk("t4_grant_stable", 64'(grant_o), 64'd1);
                    if (rx_data_valid) chk("t4_dready_mirror", 64'(rx_data_ready), 64'(m0_data_ready));
                    @(negedge clk); #3;
                    busy++;
                end
                if (busy < 9) chk("t4_busy_cycles", 64'(busy), 64'd9);
            end
        join
        wait_done();
        addr_delay = 0;

        // asynchronous reset in the middle of a data phase
        bridge_en = 1'b0;
        m0_data_ready = 1'b0;
        exp_grant.push_back({2'b01, 64'h8000_2000, 8'h03});
        req(0, 64'h8000_2000, 8'h03);
        @(negedge clk);
        rx_r_ready_o = 1'b1;
        @(posedge clk); #1;
        rx_r_ready_o = 1'b0;
        @(negedge clk);
        rx_data_read_o = 64'h1234_5678_9abc_def0;
        rx_data_valid = 1'b1;
        #1;
        chk("t5_in_data", 64'(m0_data_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        rx_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m0_data_ready = 1'b1;
        bridge_en = 1'b1;
        push(2'b01, 64'h8000_3000, 8'h0f);
        req(0, 64'h8000_3000, 8'h0f);
        wait_done();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
